isq_issue_sel: RTL and testbench

Issue-select stage directly downstream of the issue-queue lines. Each cycle it scans all lines and picks the oldest entry that is waiting (wait bit set) and has its operands ready. Oldest is measured from the queue head pointer. The picked instruction is captured in a registered issue slot with a valid/ready handshake to the functional unit. In the same cycle, a one-hot `clr_wat` pulse is driven back to the picked line.

---
 rtl/isq_pkg.sv | 41 ++++
 rtl/isq_issue_sel_if.sv | 30 +++
 rtl/isq_age_pick.sv | 39 +++
 rtl/isq_issue_sel.sv | 102 ++++++++++
 tb/tb_isq_issue_sel.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/isq_pkg.sv
// Shared issue-queue definitions: geometry of the queue and the layout of the
// instruction payload that each line carries. The line, allocator and
// issue-select blocks all import these definitions from here.
package isq_pkg;

    // Queue geometry. ISQ_DEPTH must stay a power of two so that index
    // arithmetic wraps naturally in IDX_WIDTH bits.
    localparam int INST_WIDTH = 56;
    localparam int ISQ_DEPTH  = 16;
    localparam int IDX_WIDTH  = $clog2(ISQ_DEPTH);

    // Functional-unit class carried in the top bits of every payload.
    typedef enum logic [1:0] {
        FU_ALU = 2'd0,
        FU_MUL = 2'd1,
        FU_LSU = 2'd2,
        FU_BR  = 2'd3
    } isq_fu_e;

    // Payload layout of one queue line, MSB first. The issue-select stage
    // moves it as an opaque vector; downstream units decode the fields.
    typedef struct packed {
        isq_fu_e     fu;
        logic [5:0]  opc;
        logic [5:0]  rd;
        logic [5:0]  rs1;
        logic [5:0]  rs2;
        logic [29:0] imm;
    } isq_inst_t;

    localparam int ISQ_INST_BITS = $bits(isq_inst_t);

    // Distance of a line from the head, i.e. its age rank (0 = oldest).
    function automatic logic [IDX_WIDTH-1:0] isq_age(
        input logic [IDX_WIDTH-1:0] idx,
        input logic [IDX_WIDTH-1:0] head
    );
        return idx - head;
    endfunction

endpackage

// File: rtl/isq_issue_sel_if.sv
// Issue-slot bus between the issue-select stage and a functional unit.
// The issue side presents a registered valid/payload/index; the functional
// unit answers with fu_rdy. A transfer happens on an edge with iss_vld & fu_rdy.
interface isq_issue_sel_if #(
    parameter int INST_WIDTH = isq_pkg::INST_WIDTH,
    parameter int IDX_WIDTH  = isq_pkg::IDX_WIDTH
);

    logic                  iss_vld;
    logic [INST_WIDTH-1:0] iss_inst;
    logic [IDX_WIDTH-1:0]  iss_idx;
    logic                  fu_rdy;

    // Issue-select side: drives the slot, observes acceptance.
    modport master (
        output iss_vld,
        output iss_inst,
        output iss_idx,
        input  fu_rdy
    );

    // Functional-unit side: consumes the slot, signals acceptance.
    modport slave (
        input  iss_vld,
        input  iss_inst,
        input  iss_idx,
        output fu_rdy
    );

endinterface

// File: rtl/isq_age_pick.sv
// Rotating priority encoder: picks the oldest set bit of cand, where age is
// measured upward from isq_head and wraps modulo ISQ_DEPTH. isq_head itself
// is the oldest line, isq_head-1 the youngest. Purely combinational.
module isq_age_pick #(
    parameter int ISQ_DEPTH = isq_pkg::ISQ_DEPTH,
    parameter int IDX_WIDTH = isq_pkg::IDX_WIDTH
) (
    input  logic [ISQ_DEPTH-1:0] cand,
    input  logic [IDX_WIDTH-1:0] isq_head,
    output logic                 pick_vld,
    output logic [IDX_WIDTH-1:0] pick_idx,
    output logic [ISQ_DEPTH-1:0] pick_oh
);

    logic [IDX_WIDTH-1:0] scan_idx;

    // Scan from youngest to oldest so the oldest candidate is written last and wins.
    always_comb begin
        // NOTE: every output of a combinational block gets a default before any
        // conditional write, using blocking assignments; otherwise a path that
        // skips an assignment infers a latch.
        pick_vld = 1'b0;
        pick_idx = '0;
        pick_oh  = '0;
        scan_idx = '0;
        for (int k = ISQ_DEPTH - 1; k >= 0; k--) begin
            // Adding in IDX_WIDTH bits wraps the index past the top line.
            scan_idx = isq_head + IDX_WIDTH'(k);
            if (cand[scan_idx]) begin
                pick_vld = 1'b1;
                pick_idx = scan_idx;
            end
        end
        if (pick_vld) begin
            pick_oh[pick_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/isq_issue_sel.sv
// Issue-select stage. Each cycle it picks the oldest waiting, operand-ready
// line, loads it into a registered issue slot when the slot is free, and
// pulses clr_wat back to that line in the same cycle so the line's wait bit
// and the slot update on the same edge. A flush empties the slot and blocks
// any load for that cycle.
module isq_issue_sel #(
    parameter int INST_WIDTH = isq_pkg::INST_WIDTH,
    parameter int ISQ_DEPTH  = isq_pkg::ISQ_DEPTH,
    parameter int IDX_WIDTH  = isq_pkg::IDX_WIDTH
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [ISQ_DEPTH-1:0]            lin_wat,
    input  logic [ISQ_DEPTH-1:0]            lin_rdy,
    input  logic [ISQ_DEPTH*INST_WIDTH-1:0] lin_inst,
    input  logic [IDX_WIDTH-1:0]            isq_head,
    input  logic                            fls,
    output logic [ISQ_DEPTH-1:0]            clr_wat,
    isq_issue_sel_if.master                 iss
);

    // Line view of the flattened payload bus.
    logic [INST_WIDTH-1:0] line_inst [ISQ_DEPTH];

    // Candidate selection.
    logic [ISQ_DEPTH-1:0] cand;
    logic                 pick_vld;
    logic [IDX_WIDTH-1:0] pick_idx;
    logic [ISQ_DEPTH-1:0] pick_oh;

    // Handshake.
    logic slot_free;
    logic ld;

    // Issue-slot registers.
    logic                  iss_vld_d,  iss_vld_q;
    logic [INST_WIDTH-1:0] iss_inst_d, iss_inst_q;
    logic [IDX_WIDTH-1:0]  iss_idx_d,  iss_idx_q;

    for (genvar g = 0; g < ISQ_DEPTH; g++) begin : g_line
        assign line_inst[g] = lin_inst[g*INST_WIDTH +: INST_WIDTH];
    end

    assign cand = lin_wat & lin_rdy;

    isq_age_pick #(
        .ISQ_DEPTH (ISQ_DEPTH),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_age_pick (
        .cand     (cand),
        .isq_head (isq_head),
        .pick_vld (pick_vld),
        .pick_idx (pick_idx),
        .pick_oh  (pick_oh)
    );

    // The slot can take a new entry when empty or when its entry leaves this
    // cycle; a flush suppresses the load but still lets a transfer complete.
    assign slot_free = !iss_vld_q || iss.fu_rdy;
    assign ld        = pick_vld && slot_free && !fls;

    // The clear pulse is tied to the load so a line is never picked twice;
    // held low during reset so the queue lines never see a spurious clear.
    assign clr_wat = (rst_n && ld) ? pick_oh : '0;

    // Next-state of the issue slot: load, drain on accept/flush, else hold.
    always_comb begin
        iss_vld_d  = iss_vld_q;
        iss_inst_d = iss_inst_q;
        iss_idx_d  = iss_idx_q;
        if (ld) begin
            iss_vld_d  = 1'b1;
            iss_inst_d = line_inst[pick_idx];
            iss_idx_d  = pick_idx;
        end else if (fls || iss.fu_rdy) begin
            // Payload and index are left as they are; only validity drops.
            iss_vld_d = 1'b0;
        end
    end

    // Issue-slot registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples its _d value from before the edge, independent of ordering.
        // The payload and index are reset too: they are architecturally
        // visible outputs with a defined reset value, not storage arrays.
        if (!rst_n) begin
            iss_vld_q  <= 1'b0;
            iss_inst_q <= '0;
            iss_idx_q  <= '0;
        end else begin
            iss_vld_q  <= iss_vld_d;
            iss_inst_q <= iss_inst_d;
            iss_idx_q  <= iss_idx_d;
        end
    end

    assign iss.iss_vld  = iss_vld_q;
    assign iss.iss_inst = iss_inst_q;
    assign iss.iss_idx  = iss_idx_q;

endmodule

// File: tb/tb_isq_issue_sel.sv
// Self-checking bench for isq_issue_sel. The bench plays the queue lines:
// it owns the wait bits and clears a line's wait bit when its own reference
// model says that line was issued. Every cycle the DUT outputs are compared
// against the model; directed scenarios add literal expectations on top.
module tb_isq_issue_sel;

    localparam int IW = isq_pkg::INST_WIDTH;
    localparam int D  = isq_pkg::ISQ_DEPTH;
    localparam int XW = isq_pkg::IDX_WIDTH;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [D-1:0]      lin_wat;
    logic [D-1:0]      lin_rdy;
    logic [D*IW-1:0]   lin_inst;
    logic [XW-1:0]     isq_head;
    logic              fls;
    logic [D-1:0]      clr_wat;
    logic [IW-1:0]     line_mem [D];

    isq_issue_sel_if #(.INST_WIDTH(IW), .IDX_WIDTH(XW)) iss_if ();

    isq_issue_sel dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .lin_wat  (lin_wat),
        .lin_rdy  (lin_rdy),
        .lin_inst (lin_inst),
        .isq_head (isq_head),
        .fls      (fls),
        .clr_wat  (clr_wat),
        .iss      (iss_if)
    );

    always #5 clk = ~clk;

    always_comb begin
        lin_inst = '0;
        for (int i = 0; i < D; i++) lin_inst[i*IW +: IW] = line_mem[i];
    end

    // Reference model state: contents of the issue slot as the rules dictate.
    bit            m_vld;
    logic [IW-1:0] m_inst;
    logic [XW-1:0] m_idx;
    // Expectations for the current cycle.
    int            e_pick;
    bit            e_ld;
    logic [D-1:0]  e_clr;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Oldest ready waiting line: smallest distance from head, -1 if none.
    function automatic int oldest_ready(input logic [D-1:0] wat, input logic [D-1:0] rdy,
                                        input int head);
        int best     = -1;
        int best_age = D;
        for (int i = 0; i < D; i++) begin
            if (wat[i] && rdy[i]) begin
                int age = (i - head + D) % D;
                if (age < best_age) begin
                    best_age = age;
                    best     = i;
                end
            end
        end
        return best;
    endfunction

    function automatic logic [IW-1:0] rand_inst();
        isq_pkg::isq_inst_t s;
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        s = r[IW-1:0];
        return s;
    endfunction

    task automatic set_line(input int i);
        lin_wat[i]  = 1'b1;
        line_mem[i] = rand_inst();
    endtask

    // Mid-cycle: derive this cycle's expectations and compare every output.
    task automatic sample();
        bit slot_free;
        @(negedge clk);
        e_pick    = oldest_ready(lin_wat, lin_rdy, int'(isq_head));
        slot_free = !m_vld || iss_if.fu_rdy;
        e_ld      = (e_pick >= 0) && slot_free && !fls;
        e_clr     = '0;
        if (e_ld) e_clr[e_pick] = 1'b1;
        check("iss_vld",  64'(iss_if.iss_vld),  64'(m_vld));
        check("iss_idx",  64'(iss_if.iss_idx),  64'(m_idx));
        check("iss_inst", 64'(iss_if.iss_inst), 64'(m_inst));
        check("clr_wat",  64'(clr_wat),         64'(e_clr));
    endtask

    // Clock edge: slot follows load / transfer / flush rules; the issued line
    // stops waiting. Inputs change only after the edge has settled.
    task automatic advance();
        @(posedge clk);
        #1;
        if (e_ld) begin
            m_vld  = 1'b1;
            m_inst = line_mem[e_pick];
            m_idx  = XW'(e_pick);
            lin_wat[e_pick] = 1'b0;
        end else if (m_vld && (iss_if.fu_rdy || fls)) begin
            m_vld = 1'b0;
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        lin_wat       = '0;
        lin_rdy       = '1;
        isq_head      = '0;
        fls           = 1'b0;
        iss_if.fu_rdy = 1'b0;
        for (int i = 0; i < D; i++) line_mem[i] = rand_inst();
        m_vld  = 1'b0;
        m_inst = '0;
        m_idx  = '0;

        // Reset values, and no clear pulse while reset is held even with a candidate.
        #2;
        check("rst_vld",  64'(iss_if.iss_vld),  64'd0);
        check("rst_inst", 64'(iss_if.iss_inst), 64'd0);
        check("rst_idx",  64'(iss_if.iss_idx),  64'd0);
        lin_wat = 16'h0001;
        #1;
        check("rst_clr",  64'(clr_wat), 64'd0);
        lin_wat = '0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Idle: no candidates for 10 cycles.
        for (int c = 0; c < 10; c++) begin
            sample();
            check("idle_vld", 64'(iss_if.iss_vld), 64'd0);
            check("idle_clr", 64'(clr_wat), 64'd0);
            advance();
        end

        // Head wrap: head 14, candidates 2 and 15.
        isq_head = XW'(14);
        iss_if.fu_rdy = 1'b1;
        set_line(2);
        set_line(15);
        sample();
        check("wrap_c0_clr", 64'(clr_wat), 64'h8000);
        advance();
        sample();
        check("wrap_c1_idx", 64'(iss_if.iss_idx), 64'd15);
        check("wrap_c1_vld", 64'(iss_if.iss_vld), 64'd1);
        check("wrap_c1_clr", 64'(clr_wat), 64'h0004);
        advance();
        sample();
        check("wrap_c2_idx", 64'(iss_if.iss_idx), 64'd2);
        advance();

        // Stall: slot holds line 5 while line 7 waits.
        isq_head = '0;
        set_line(5);
        sample();
        advance();
        iss_if.fu_rdy = 1'b0;
        set_line(7);
        for (int c = 0; c < 3; c++) begin
            sample();
            check("stall_idx", 64'(iss_if.iss_idx), 64'd5);
            check("stall_vld", 64'(iss_if.iss_vld), 64'd1);
            check("stall_clr", 64'(clr_wat), 64'd0);
            advance();
        end
        iss_if.fu_rdy = 1'b1;
        sample();
        check("unstall_clr", 64'(clr_wat), 64'h0080);
        advance();
        sample();
        check("unstall_idx", 64'(iss_if.iss_idx), 64'd7);
        advance();

        // Back-to-back: lines 0..3 issue on consecutive cycles.
        for (int i = 0; i < 4; i++) set_line(i);
        sample();
        advance();
        for (int k = 0; k < 4; k++) begin
            sample();
            check("b2b_idx", 64'(iss_if.iss_idx), 64'(k));
            check("b2b_vld", 64'(iss_if.iss_vld), 64'd1);
            advance();
        end
        sample();
        check("b2b_end_vld", 64'(iss_if.iss_vld), 64'd0);
        advance();

        // Flush with a valid slot and line 4 waiting.
        iss_if.fu_rdy = 1'b0;
        set_line(9);
        sample();
        advance();
        set_line(4);
        fls = 1'b1;
        sample();
        check("fls_clr", 64'(clr_wat), 64'd0);
        advance();
        fls = 1'b0;
        sample();
        check("fls_vld",     64'(iss_if.iss_vld), 64'd0);
        check("post_fls_clr", 64'(clr_wat), 64'h0010);
        advance();
        sample();
        check("post_fls_vld", 64'(iss_if.iss_vld), 64'd1);
        check("post_fls_idx", 64'(iss_if.iss_idx), 64'd4);
        advance();

        // Asynchronous reset between edges while the slot stalls on line 4.
        rst_n = 1'b0;
        #1;
        check("arst_vld",  64'(iss_if.iss_vld),  64'd0);
        check("arst_idx",  64'(iss_if.iss_idx),  64'd0);
        check("arst_inst", 64'(iss_if.iss_inst), 64'd0);
        check("arst_clr",  64'(clr_wat), 64'd0);
        lin_wat = '0;
        m_vld   = 1'b0;
        m_inst  = '0;
        m_idx   = '0;
        #2;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            sample();
            check("arst_idle_vld", 64'(iss_if.iss_vld), 64'd0);
            advance();
        end
        iss_if.fu_rdy = 1'b1;
        set_line(11);
        sample();
        advance();
        sample();
        check("arst_resume_idx", 64'(iss_if.iss_idx), 64'd11);
        advance();

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            isq_head      = XW'($urandom());
            lin_rdy       = D'($urandom());
            iss_if.fu_rdy = ($urandom_range(0, 3) != 0);
            fls           = ($urandom_range(0, 19) == 0);
            for (int i = 0; i < D; i++) begin
                if (!lin_wat[i] && $urandom_range(0, 3) == 0) set_line(i);
            end
            sample();
            advance();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
